// File: rtl/sseg_scan_ctrl_pkg.sv
// Shared definitions for the seven-segment scan controller: FSM encoding,
// dark-display constants and the active-low hex segment table.
package sseg_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    BLANK = 2'd2
  } scan_state_t;

  localparam logic [3:0] AN_OFF  = 4'hF;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Segment order {g,f,e,d,c,b,a}; a 0 bit lights the segment.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic logic [3:0] an_onehot_low(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/sseg_scan_ctrl_if.sv
// Datapath-side and pin-side signals of the scan controller; the controller
// is the slave, whoever supplies the hex value and watches the pins is master.
interface sseg_scan_ctrl_if;

  logic        en;
  logic        lzb;
  logic [15:0] digits;
  logic [3:0]  dp;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp_n;
  logic        frame_tick;

  modport master (
    output en, lzb, digits, dp,
    input  an, seg, dp_n, frame_tick
  );

  modport slave (
    input  en, lzb, digits, dp,
    output an, seg, dp_n, frame_tick
  );

endinterface

// File: rtl/sseg_scan_ctrl_hex_to_sseg.sv
// Combinational 4-bit hex to active-low seven-segment decoder.
module hex_to_sseg
  import sseg_scan_ctrl_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[hex];

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Four-digit common-anode display scanner: SHOW slots separated by all-off
// BLANK gaps, optional leading-zero blanking, registered pin outputs.
module sseg_scan_ctrl
  import sseg_scan_ctrl_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic           clk,
  input  logic           rst,
  sseg_scan_ctrl_if.slave bus
);

  if (SCAN_DIV < 2 || SCAN_DIV > 65536) begin : g_bad_scan_div
    $error("sseg_scan_ctrl: SCAN_DIV=%0d outside 2..65536", SCAN_DIV);
  end
  if (BLANK_CYCLES < 1 || BLANK_CYCLES > 256) begin : g_bad_blank_cycles
    $error("sseg_scan_ctrl: BLANK_CYCLES=%0d outside 1..256", BLANK_CYCLES);
  end

  localparam logic [15:0] SCAN_TC  = 16'(SCAN_DIV - 1);
  localparam logic [7:0]  BLANK_TC = 8'(BLANK_CYCLES - 1);

  scan_state_t state, state_nxt;
  logic [1:0]  idx, idx_nxt;
  logic [15:0] presc, presc_nxt;
  logic [7:0]  blank_cnt, blank_nxt;
  logic [3:0]  an_nxt;
  logic [6:0]  seg_nxt;
  logic        dpn_nxt;
  logic        ft_nxt;
  logic [3:0]  suppress;
  logic [3:0]  nibble;
  logic [6:0]  seg_dec;

  // A digit is suppressed only when it and every digit to its left are zero.
  always_comb begin
    suppress = 4'b0000;
    if (bus.lzb) begin
      suppress[3] = (bus.digits[15:12] == 4'h0);
      suppress[2] = suppress[3] && (bus.digits[11:8] == 4'h0);
      suppress[1] = suppress[2] && (bus.digits[7:4] == 4'h0);
    end
  end

  assign nibble = bus.digits[{idx_nxt, 2'b00} +: 4];

  hex_to_sseg u_dec (
    .hex (nibble),
    .seg (seg_dec)
  );

  // Counters are cleared whenever their state is not being continued.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    presc_nxt = '0;
    blank_nxt = '0;
    ft_nxt    = 1'b0;
    if (!bus.en) begin
      state_nxt = IDLE;
      idx_nxt   = 2'd0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = SHOW;
          idx_nxt   = 2'd0;
        end
        SHOW: begin
          if (presc == SCAN_TC) state_nxt = BLANK;
          else                  presc_nxt = presc + 16'd1;
        end
        BLANK: begin
          if (blank_cnt == BLANK_TC) begin
            state_nxt = SHOW;
            idx_nxt   = idx + 2'd1;
            ft_nxt    = (idx == 2'd3);
          end else begin
            blank_nxt = blank_cnt + 8'd1;
          end
        end
        default: begin
          state_nxt = IDLE;
          idx_nxt   = 2'd0;
        end
      endcase
    end
  end

  // Pins are computed from the upcoming state so they change on the same edge.
  always_comb begin
    an_nxt  = AN_OFF;
    seg_nxt = SEG_OFF;
    dpn_nxt = 1'b1;
    if (state_nxt == SHOW && !suppress[idx_nxt]) begin
      an_nxt  = an_onehot_low(idx_nxt);
      seg_nxt = seg_dec;
      dpn_nxt = ~bus.dp[idx_nxt];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      idx            <= 2'd0;
      presc          <= '0;
      blank_cnt      <= '0;
      bus.an         <= AN_OFF;
      bus.seg        <= SEG_OFF;
      bus.dp_n       <= 1'b1;
      bus.frame_tick <= 1'b0;
    end else begin
      state          <= state_nxt;
      idx            <= idx_nxt;
      presc          <= presc_nxt;
      blank_cnt      <= blank_nxt;
      bus.an         <= an_nxt;
      bus.seg        <= seg_nxt;
      bus.dp_n       <= dpn_nxt;
      bus.frame_tick <= ft_nxt;
    end
  end

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Scoreboard bench for sseg_scan_ctrl with SCAN_DIV=4, BLANK_CYCLES=2:
// the driver queues the pin values expected after each edge, a monitor checks them.
module tb_sseg_scan_ctrl;

  logic clk;
  logic rst;

  sseg_scan_ctrl_if bus ();

  sseg_scan_ctrl #(
    .SCAN_DIV     (4),
    .BLANK_CYCLES (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int         cyc;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp_n;
    logic       ft;
    string      name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc_count   = 0;
  int   check_count = 0;
  int   pass_count  = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc_count <= cyc_count + 1;

  task automatic checkOutput(input string name, input logic [3:0] an,
                             input logic [6:0] seg, input logic dpn, input logic ft);
    check_count++;
    if (bus.an === an && bus.seg === seg && bus.dp_n === dpn && bus.frame_tick === ft)
      pass_count++;
    else
      $display("[TB] FAIL %s cyc=%0d: got an=%b seg=%h dp_n=%b ft=%b, want an=%b seg=%h dp_n=%b ft=%b",
               name, cyc_count, bus.an, bus.seg, bus.dp_n, bus.frame_tick, an, seg, dpn, ft);
  endtask

  // Pops every expectation due by this cycle; sampling on negedge keeps it clear of the active edge.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc_count) begin
      mon_e = sb.pop_front();
      checkOutput(mon_e.name, mon_e.an, mon_e.seg, mon_e.dp_n, mon_e.ft);
    end
  end

  task automatic applyStimulus(input logic en, input logic lzb,
                               input logic [15:0] digits, input logic [3:0] dp);
    bus.en     = en;
    bus.lzb    = lzb;
    bus.digits = digits;
    bus.dp     = dp;
  endtask

  task automatic step(input logic [3:0] an, input logic [6:0] seg, input logic dpn,
                      input logic ft, input string name);
    exp_t e;
    e.cyc  = cyc_count + 1;
    e.an   = an;
    e.seg  = seg;
    e.dp_n = dpn;
    e.ft   = ft;
    e.name = name;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic show(input int d, input logic [6:0] seg, input logic dpn,
                      input logic ft_first, input int n, input string name);
    logic [3:0] an;
    an = ~(4'b0001 << d);
    for (int i = 0; i < n; i++)
      step(an, seg, dpn, (i == 0) ? ft_first : 1'b0, name);
  endtask

  task automatic dark(input int n, input string name);
    for (int i = 0; i < n; i++)
      step(4'hF, 7'h7F, 1'b1, 1'b0, name);
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 16'h0000, 4'b0000);
    @(negedge clk);
    #1;
    dark(1, "reset");

    // Plain 1234 frame, then the wrap into digit 0 carries frame_tick.
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 16'h1234, 4'b0000);
    show(0, 7'h19, 1'b1, 1'b0, 4, "f1_d0");
    dark(2, "f1_b0");
    show(1, 7'h30, 1'b1, 1'b0, 4, "f1_d1");
    dark(2, "f1_b1");
    show(2, 7'h24, 1'b1, 1'b0, 4, "f1_d2");
    dark(2, "f1_b2");
    show(3, 7'h79, 1'b1, 1'b0, 4, "f1_d3");
    dark(2, "f1_b3");
    show(0, 7'h19, 1'b1, 1'b1, 4, "f2_d0_wrap");
    dark(2, "f2_b0");
    show(1, 7'h30, 1'b1, 1'b0, 4, "f2_d1");
    dark(2, "f2_b1");
    show(2, 7'h24, 1'b1, 1'b0, 2, "f2_d2");

    // Drop enable mid digit 2, then restart from digit 0 with a full slot.
    applyStimulus(1'b0, 1'b0, 16'h1234, 4'b0000);
    dark(2, "en_off");
    applyStimulus(1'b1, 1'b0, 16'h1234, 4'b0000);
    show(0, 7'h19, 1'b1, 1'b0, 4, "restart_d0");
    dark(2, "restart_b0");
    show(1, 7'h30, 1'b1, 1'b0, 1, "restart_d1");

    // Leading-zero blanking on 0050 with dp requested on a blanked digit.
    applyStimulus(1'b0, 1'b1, 16'h0050, 4'b1000);
    dark(1, "idle_lzb");
    applyStimulus(1'b1, 1'b1, 16'h0050, 4'b1000);
    show(0, 7'h40, 1'b1, 1'b0, 4, "lzb_d0");
    dark(2, "lzb_b0");
    show(1, 7'h12, 1'b1, 1'b0, 4, "lzb_d1");
    dark(2, "lzb_b1");
    dark(4, "lzb_d2_off");
    dark(2, "lzb_b2");
    dark(4, "lzb_d3_dp_off");
    dark(2, "lzb_b3");
    show(0, 7'h40, 1'b1, 1'b1, 4, "lzb_wrap");

    // All-zero value: only digit 0 with lzb, every digit without it.
    applyStimulus(1'b0, 1'b1, 16'h0000, 4'b0000);
    dark(1, "idle_zero");
    applyStimulus(1'b1, 1'b1, 16'h0000, 4'b0000);
    show(0, 7'h40, 1'b1, 1'b0, 4, "zero_d0");
    dark(2, "zero_b0");
    dark(4, "zero_d1_off");
    dark(2, "zero_b1");
    dark(4, "zero_d2_off");
    dark(2, "zero_b2");
    dark(4, "zero_d3_off");
    dark(2, "zero_b3");
    show(0, 7'h40, 1'b1, 1'b1, 1, "zero_wrap");
    applyStimulus(1'b1, 1'b0, 16'h0000, 4'b0000);
    show(0, 7'h40, 1'b1, 1'b0, 3, "nolzb_d0");
    dark(2, "nolzb_b0");
    show(1, 7'h40, 1'b1, 1'b0, 4, "nolzb_d1");
    dark(2, "nolzb_b1");
    show(2, 7'h40, 1'b1, 1'b0, 4, "nolzb_d2");
    dark(2, "nolzb_b2");
    show(3, 7'h40, 1'b1, 1'b0, 4, "nolzb_d3");
    dark(1, "nolzb_b3a");

    // Live data change inside digit 0's slot, with its decimal point lit.
    applyStimulus(1'b1, 1'b0, 16'h0001, 4'b0001);
    dark(1, "nolzb_b3b");
    show(0, 7'h79, 1'b0, 1'b1, 2, "data_old");
    applyStimulus(1'b1, 1'b0, 16'h000F, 4'b0001);
    show(0, 7'h0E, 1'b0, 1'b0, 2, "data_new");
    dark(2, "data_b0");
    show(1, 7'h40, 1'b1, 1'b0, 2, "pre_rst_d1");

    // Asynchronous reset inside a SHOW slot, then inside a BLANK gap.
    rst = 1'b1;
    #1;
    checkOutput("async_rst_show", 4'hF, 7'h7F, 1'b1, 1'b0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    show(0, 7'h0E, 1'b0, 1'b0, 4, "post_rst_d0");
    dark(1, "post_rst_b0");
    rst = 1'b1;
    #1;
    checkOutput("async_rst_blank", 4'hF, 7'h7F, 1'b1, 1'b0);
    rst = 1'b0;
    show(0, 7'h0E, 1'b0, 1'b0, 4, "post_rst2_d0");
    dark(2, "post_rst2_b0");
    show(1, 7'h40, 1'b1, 1'b0, 1, "post_rst2_d1");

    check_count++;
    if (sb.size() == 0) pass_count++;
    else $display("[TB] FAIL scoreboard_drain: %0d entries left, want 0", sb.size());

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/sseg_scan_ctrl.md
Name: sseg_scan_ctrl

Overview:
Time-multiplexed scan controller for the board's 4-digit common-anode seven-segment display. It shares the single segment bus among four digits using an internal prescaler of the same terminal-count style as the team's clock divider. It inserts a blanking interval between digit slots to prevent ghosting, and applies optional leading-zero blanking. It sits between the datapath's 16-bit hex value and the display pins.

Parameters:
SCAN_DIV, 50000, clock cycles each digit is driven (SHOW slot length); legal range 2..65536.
BLANK_CYCLES, 16, clock cycles all anodes are off between slots; legal range 1..256.

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
en  in  1  1 = scan display; 0 = display dark
lzb  in  1  1 = enable leading-zero blanking
digits  in  16  hex value; [3:0] = digit 0 (rightmost), [15:12] = digit 3
dp  in  4  decimal point request per digit, 1 = lit
an  out  4  anode enables, active-low, an[i] drives digit i
seg  out  7  segments {g,f,e,d,c,b,a}, active-low
dp_n  out  1  decimal point, active-low
frame_tick  out  1  one-cycle pulse when digit index wraps 3->0

Behaviour:
- Reset (async): state IDLE; idx=0; prescaler=0; blank counter=0; an=4'hF; seg=7'h7F; dp_n=1; frame_tick=0.
- All outputs are registered. They update on the same edge as the state transition that causes them, because they are loaded from next-state logic.
- Prescaler: 16-bit counter, counts 0..SCAN_DIV-1 in SHOW only; tc = (count == SCAN_DIV-1). It clears on entering SHOW.
- Blank counter: 8-bit counter, counts 0..BLANK_CYCLES-1 in BLANK only; it clears on entering BLANK.
- FSM:
  - IDLE: outputs dark. If en=1, go to SHOW with idx=0.
  - SHOW: an = one-hot-low on idx; seg = decode(nibble idx); dp_n = ~dp[idx]. On tc, go to BLANK.
  - BLANK: an=4'hF, seg=7'h7F, dp_n=1. On the last blank cycle, idx <= idx+1 mod 4 and go to SHOW. When idx wraps 3->0, frame_tick=1 for exactly that cycle.
- SHOW lasts exactly SCAN_DIV cycles and BLANK exactly BLANK_CYCLES cycles. Frame period = 4*(SCAN_DIV+BLANK_CYCLES) cycles.
- en=0 in any state: next edge goes to IDLE with all outputs dark, idx=0, counters cleared, no frame_tick. Re-enabling always restarts at digit 0.
- Digit data is not latched per slot. seg/dp_n track changes to digits/dp with 1-cycle latency while in SHOW.
- Leading-zero blanking (lzb=1):
  - Digit i (i=3..1) is suppressed if nibble i and all higher nibbles are 0. Digit 0 is never suppressed.
  - A suppressed slot keeps its timing but holds an=4'hF, seg=7'h7F, dp_n=1, even if its dp bit is set.
- Decode, active-low hex: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
- An out-of-range parameter is a configuration error. It is caught by an elaboration-time check.

Decomposition:
- Shared package: FSM state encoding (IDLE, SHOW, BLANK), the dark constants (AN_OFF=4'hF, SEG_OFF=7'h7F), and the 16-entry segment code table.
- One sub-module: hex_to_sseg, a combinational 4-bit to 7-bit active-low decoder. It is instantiated once on the selected nibble.

Test Plan (SCAN_DIV=4, BLANK_CYCLES=2 unless noted):
- Reset then en=1, digits=16'h1234, dp=0, lzb=0 -> an sequence 1110 (seg=19, 4 cycles), 1111 (2 cycles), 1101 (seg=30), 1111, 1011 (seg=24), 1111, 0111 (seg=79), 1111. frame_tick pulses once on the 3->0 wrap; period 24 cycles.
- digits=16'h0050, lzb=1, dp=4'b1000 -> slots 3 and 2 dark, including dp; slot 1 seg=12; slot 0 seg=40. Same 24-cycle frame.
- digits=16'h0000, lzb=1 -> only digit 0 lit (seg=40). With lzb=0, all four show 40.
- Deassert en mid-SHOW of digit 2 -> next edge an=F, seg=7F, dp_n=1, no frame_tick. Reassert -> resumes at digit 0 with a full 4-cycle slot.
- Assert rst mid-BLANK without a clock edge -> outputs dark immediately. Release with en=1 -> digit 0 shown after the next edge.
- Change digits during a SHOW slot (digit 0: 1->F) -> seg changes 79->0E one cycle later. Slot length is unaffected.
